// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Fetch entries pair a word-aligned PC with the instruction fetched from it.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam int          QUEUE_DEPTH       = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetch entries between the imem response path and IF/ID.
// Flush dominates push and pop; push and pop together on a full queue is legal.
module fetch_queue
    import pipeline_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t r_mem [QUEUE_DEPTH];
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_wr_ptr;
    logic w_do_pop;
    logic w_do_push;

    // With two slots the write slot is the read slot offset by the occupancy parity.
    assign w_wr_ptr  = r_rd_ptr ^ r_count[0];
    assign w_do_pop  = pop && (r_count != 2'd0) && !flush;
    assign w_do_push = push && !flush && !rst && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_ptr] <= din;
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch producer: owns the PC, issues single-outstanding word fetches
// and presents queued {pc, instr} pairs to the IF/ID register.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pcPlus4F,
    output logic [31:0] instrF,
    output logic        validF
);

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_outstanding;
    logic        r_drop;

    logic [1:0]   w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;
    logic         w_valid;
    logic         w_pop;
    logic         w_req;
    logic         w_accept;
    logic         w_push;

    assign w_valid  = !rst && (w_count != 2'd0);
    assign w_pop    = w_valid && !stallF;
    // Issue only when the returning word is guaranteed a free slot.
    assign w_req    = !rst && !r_outstanding && ((w_count - {1'b0, w_pop}) < 2'd2);
    assign w_accept = w_req && imem_ready;
    assign w_push   = imem_rvalid && r_outstanding && !r_drop && !redirect;

    assign w_push_entry.pc    = r_req_pc;
    assign w_push_entry.instr = imem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_req_pc      <= 32'h0;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_pc;
                r_pc          <= r_pc + 32'd4;
            end else if (imem_rvalid && r_outstanding) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
            // A redirect poisons whatever is in flight unless its response lands now.
            if (redirect) begin
                r_pc <= redirectPc & ~32'h3;
                if (w_accept || (r_outstanding && !imem_rvalid)) begin
                    r_drop <= 1'b1;
                end
            end
        end
    end

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect),
        .din   (w_push_entry),
        .count (w_count),
        .head  (w_head)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign validF    = w_valid;
    assign pcF       = w_valid ? w_head.pc : 32'h0;
    assign pcPlus4F  = w_valid ? (w_head.pc + 32'd4) : 32'h0;
    assign instrF    = w_valid ? w_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run,
// checked every cycle against a transaction-level model with fetch epochs.
module tb_fetch_unit;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, stallF = 1'b0, redirect = 1'b0;
    logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] redirectPc = 32'h0, imem_rdata = 32'h0;
    logic        imem_req, validF;
    logic [31:0] imem_addr, pcF, pcPlus4F, instrF;
    logic        wrap_req, wrap_validF;
    logic [31:0] wrap_addr, wrap_pcF, wrap_pcPlus4F, wrap_instrF;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .stallF(stallF), .redirect(redirect), .redirectPc(redirectPc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pcF(pcF), .pcPlus4F(pcPlus4F), .instrF(instrF), .validF(validF)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stallF(stallF), .redirect(redirect), .redirectPc(redirectPc),
        .imem_req(wrap_req), .imem_addr(wrap_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pcF(wrap_pcF), .pcPlus4F(wrap_pcPlus4F), .instrF(wrap_instrF), .validF(wrap_validF)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Model: queue of deliverable entries, next fetch address, one in-flight fetch
    // tagged with the epoch it was issued in. Redirect/reset start a new epoch.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_busy = 1'b0;
    logic [31:0] m_busy_pc = 32'h0;
    int          m_busy_epoch = 0;
    int          m_epoch = 0;

    // Memory responder driven by the model's view of accepts.
    int          rsp_due[$];
    logic [31:0] rsp_addr[$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    bit          spurious = 1'b0;
    bit          wrap_chk = 1'b0;

    // Logs observed from the DUTs for literal expectations.
    logic [31:0] acc_log[$], pop_log[$], wrap_acc[$];
    int          first_rv_cyc = -1, first_v_cyc = -1;
    logic [31:0] wrap_first_p4 = 32'hDEAD_BEEF;
    bit          wrap_first_seen = 1'b0;
    int          req_seen = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic clear_logs();
        acc_log.delete();
        pop_log.delete();
        wrap_acc.delete();
        req_seen = 0;
    endtask

    task automatic step(input bit s_rst, input bit s_stall, input bit s_redir,
                        input logic [31:0] s_rpc, input bit s_ready);
        bit          rv, exp_pop, exp_req, acc, push, exp_valid;
        logic [31:0] rd;
        @(negedge clk);
        rv = 1'b0;
        rd = $urandom;
        if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
            rv = 1'b1;
            rd = mem_word(rsp_addr[0]);
            void'(rsp_due.pop_front());
            void'(rsp_addr.pop_front());
        end else if (spurious && rsp_due.size() == 0 && !m_busy && $urandom_range(0, 9) == 0) begin
            rv = 1'b1;
        end
        rst = s_rst; stallF = s_stall; redirect = s_redir; redirectPc = s_rpc;
        imem_ready = s_ready; imem_rvalid = rv; imem_rdata = rd;
        #1;
        exp_valid = !s_rst && mq.size() > 0;
        exp_pop   = exp_valid && !s_stall;
        exp_req   = !s_rst && !m_busy && (mq.size() - int'(exp_pop)) < 2;

        check("validF", validF, exp_valid);
        if (exp_valid) begin
            check("pcF", pcF, mq[0].pc);
            check("pcPlus4F", pcPlus4F, mq[0].pc + 32'd4);
            check("instrF", instrF, mq[0].instr);
        end else begin
            check("pcF_idle", pcF, 32'h0);
            check("pcPlus4F_idle", pcPlus4F, 32'h0);
            check("instrF_idle", instrF, NOP_INSTR_DEFAULT);
        end
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        if (wrap_chk) begin
            check("wrap_validF", wrap_validF, exp_valid);
            check("wrap_req", wrap_req, exp_req);
            if (exp_req) check("wrap_addr", wrap_addr, m_pc - 32'd4);
            if (exp_valid) check("wrap_pcF", wrap_pcF, mq[0].pc - 32'd4);
            if (wrap_req && s_ready) wrap_acc.push_back(wrap_addr);
            if (wrap_validF && !wrap_first_seen) begin
                wrap_first_seen = 1'b1;
                wrap_first_p4   = wrap_pcPlus4F;
            end
        end

        if (!s_rst && imem_req && s_ready) acc_log.push_back(imem_addr);
        if (!s_rst && imem_req) req_seen++;
        if (validF && !s_stall) pop_log.push_back(pcF);
        if (first_rv_cyc < 0 && rv) first_rv_cyc = cyc;
        if (first_v_cyc < 0 && validF) first_v_cyc = cyc;

        acc  = exp_req && s_ready;
        push = rv && m_busy && (m_busy_epoch == m_epoch) && !s_redir;
        if (s_rst) begin
            mq.delete();
            m_pc   = RESET_PC_DEFAULT;
            m_busy = 1'b0;
            m_epoch++;
        end else begin
            if (exp_pop) void'(mq.pop_front());
            if (push) mq.push_back('{m_busy_pc, rd});
            if (rv && m_busy) m_busy = 1'b0;
            if (acc) begin
                m_busy       = 1'b1;
                m_busy_pc    = m_pc;
                m_busy_epoch = m_epoch;
                rsp_due.push_back(cyc + $urandom_range(lat_min, lat_max));
                rsp_addr.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (s_redir) begin
                mq.delete();
                m_pc = s_rpc & ~32'h3;
                m_epoch++;
            end
        end
        cyc++;
    endtask

    initial begin
        // 1: reset then streaming fetch, ready=1, one-cycle latency
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        clear_logs();
        first_rv_cyc = -1; first_v_cyc = -1;
        wrap_chk = 1'b1;
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
        wrap_chk = 1'b0;
        if (acc_log.size() >= 3) begin
            check("t1_addr0", acc_log[0], 32'h0);
            check("t1_addr1", acc_log[1], 32'h4);
            check("t1_addr2", acc_log[2], 32'h8);
        end else fail_bound("t1_accepts");
        if (pop_log.size() >= 2) begin
            check("t1_pop0", pop_log[0], 32'h0);
            check("t1_pop1", pop_log[1], 32'h4);
        end else fail_bound("t1_pops");
        check("t1_rvalid_to_validF", 32'(first_v_cyc - first_rv_cyc), 32'd1);
        if (wrap_acc.size() >= 2) begin
            check("t5_wrap_addr0", wrap_acc[0], 32'hFFFF_FFFC);
            check("t5_wrap_addr1", wrap_acc[1], 32'h0000_0000);
        end else fail_bound("t5_wrap_accepts");
        check("t5_wrap_pcPlus4F", wrap_first_p4, 32'h0);

        // 2: stall with two words queued
        for (int k = 0; k < 20 && !(mq.size() == 2 && !m_busy); k++) step(0, 1, 0, 0, 1);
        if (!(mq.size() == 2 && !m_busy)) fail_bound("t2_fill");
        begin
            logic [31:0] h;
            h = mq[0].pc;
            clear_logs();
            for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1);
            check("t2_req_during_stall", 32'(req_seen), 32'd0);
            clear_logs();
            for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
            if (pop_log.size() >= 3) begin
                check("t2_release0", pop_log[0], h);
                check("t2_release1", pop_log[1], h + 32'd4);
                check("t2_release2", pop_log[2], h + 32'd8);
            end else fail_bound("t2_release");
        end

        // 3: redirect to 0x103 while a request is outstanding
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 20 && !m_busy; k++) step(0, 0, 0, 0, 1);
        if (!m_busy) fail_bound("t3_busy");
        step(0, 0, 1, 32'h0000_0103, 1);
        clear_logs();
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
        if (acc_log.size() >= 1) check("t3_next_addr", acc_log[0], 32'h100);
        else fail_bound("t3_accept");
        if (pop_log.size() >= 1) check("t3_first_pc", pop_log[0], 32'h100);
        else fail_bound("t3_pop");

        // 4a: redirect in the same cycle as an accept
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 20 && !(!m_busy && mq.size() < 2); k++) step(0, 0, 0, 0, 0);
        if (m_busy || mq.size() >= 2) fail_bound("t4a_idle");
        step(0, 1, 1, 32'h0000_0100, 1);
        clear_logs();
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
        if (pop_log.size() >= 1) check("t4a_first_pc", pop_log[0], 32'h100);
        else fail_bound("t4a_pop");

        // 4b: redirect in the same cycle as an rvalid
        for (int k = 0; k < 20 && !(m_busy && rsp_due.size() > 0 && rsp_due[0] == cyc); k++)
            step(0, 0, 0, 0, 1);
        if (!(m_busy && rsp_due.size() > 0 && rsp_due[0] == cyc)) fail_bound("t4b_align");
        step(0, 0, 1, 32'h0000_0100, 1);
        clear_logs();
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
        if (pop_log.size() >= 1) check("t4b_first_pc", pop_log[0], 32'h100);
        else fail_bound("t4b_pop");

        // randomized traffic
        lat_min = 1; lat_max = 4; spurious = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bit          r_redir;
            logic [31:0] tgt;
            r_redir = ($urandom_range(0, 99) < 5);
            tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFF);
            step(0, ($urandom_range(0, 99) < 30), r_redir, tgt, ($urandom_range(0, 99) < 70));
        end
        spurious = 1'b0;

        // 6: reset with a request in flight; its late rvalid must be ignored
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 20 && !m_busy; k++) step(0, 0, 0, 0, 1);
        if (!m_busy) fail_bound("t6_busy");
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        check("t6_validF", validF, 1'b0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_req", imem_req, 1'b1);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
